// File: rtl/axi_node_pkg.sv
// Shared definitions for the AXI node slave-port slice.
//   w_seq_state_e     : W sequencer FSM states
//   MAX_BEATS_DEFAULT : default burst length limit
//   idx_width()       : index width for N items, never below 1 bit
package axi_node_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ROUTE = 1'b1
  } w_seq_state_e;

  localparam int unsigned MAX_BEATS_DEFAULT = 256;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/axi_node_w_sequencer_if.sv
// AW-grant and W-channel handshake bundle of one slave-port slice.
//   aw_valid_i/aw_mst_i/aw_ready_o    : AW grant recording
//   inp_w_valid_i/last_i/ready_o      : per-master W channel
//   oup_w_valid_o/last_o/ready_i/sel_o: W channel toward the slave, mux select
// slave modport = sequencer side, master modport = surrounding logic.
interface axi_node_w_sequencer_if
  import axi_node_pkg::*;
#(
  parameter int unsigned N_MASTER = 4
) ();
  localparam int unsigned IDX_W = idx_width(N_MASTER);

  logic                aw_valid_i;
  logic [IDX_W-1:0]    aw_mst_i;
  logic                aw_ready_o;
  logic [N_MASTER-1:0] inp_w_valid_i;
  logic [N_MASTER-1:0] inp_w_last_i;
  logic [N_MASTER-1:0] inp_w_ready_o;
  logic                oup_w_valid_o;
  logic                oup_w_last_o;
  logic                oup_w_ready_i;
  logic [IDX_W-1:0]    oup_w_sel_o;

  modport slave (
    input  aw_valid_i, aw_mst_i, inp_w_valid_i, inp_w_last_i, oup_w_ready_i,
    output aw_ready_o, inp_w_ready_o, oup_w_valid_o, oup_w_last_o, oup_w_sel_o
  );

  modport master (
    output aw_valid_i, aw_mst_i, inp_w_valid_i, inp_w_last_i, oup_w_ready_i,
    input  aw_ready_o, inp_w_ready_o, oup_w_valid_o, oup_w_last_o, oup_w_sel_o
  );
endinterface

// File: rtl/axi_node_idx_fifo.sv
// In-order queue of master indices (one entry per granted AW).
//   clk_i, rst_i     : clock, synchronous active-high reset
//   push_i, data_i   : enqueue (ignored when full)
//   pop_i            : dequeue head (ignored when empty)
//   head_o           : registered head entry
//   full_o, empty_o  : status
//   count_o          : occupancy 0..DEPTH
module axi_node_idx_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [W-1:0]             data_i,
  input  logic                     pop_i,
  output logic [W-1:0]             head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: rtl/axi_node_w_sequencer.sv
// Orders the W channel behind the AW grants of a slave port: each accepted
// AW's master index is queued, and that master's W beats are routed to the
// slave until WLAST, then the next queued master takes over.
//   clk_i, rst_i : clock, synchronous active-high reset
//   bus          : AW grant + W handshake bundle (slave modport)
//   busy_o       : a burst is being routed
//   pending_o    : queued grants including the current one
//   err_len_o    : sticky, a burst ran past MAX_BEATS without WLAST
module axi_node_w_sequencer
  import axi_node_pkg::*;
#(
  parameter int unsigned N_MASTER  = 4,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned MAX_BEATS = MAX_BEATS_DEFAULT
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  axi_node_w_sequencer_if.slave  bus,
  output logic                   busy_o,
  output logic [$clog2(DEPTH):0] pending_o,
  output logic                   err_len_o
);
  localparam int unsigned IDX_W = idx_width(N_MASTER);
  localparam int unsigned CNT_W = $clog2(MAX_BEATS) + 1;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  w_seq_state_e        state_q;
  logic [IDX_W-1:0]    sel_hold_q;
  logic [CNT_W-1:0]    beat_cnt_q;
  logic                err_len_q;

  logic [IDX_W-1:0]    head;
  logic                fifo_full, fifo_empty;
  logic [CW-1:0]       fifo_count;
  logic                aw_ready, aw_push;
  logic                route;
  logic                w_valid, w_last, w_hs, w_last_hs;
  logic [N_MASTER-1:0] w_ready;

  // Readies are masked during reset so no beat or grant slips through
  // in the reset cycle itself.
  assign aw_ready = !fifo_full && !rst_i;
  assign aw_push  = bus.aw_valid_i && aw_ready;
  assign route    = (state_q == ROUTE) && !rst_i;

  axi_node_idx_fifo #(
    .DEPTH (DEPTH),
    .W     (IDX_W)
  ) u_idx_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (aw_push),
    .data_i  (bus.aw_mst_i),
    .pop_i   (w_last_hs),
    .head_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    w_valid = 1'b0;
    w_last  = 1'b0;
    w_ready = '0;
    if (route) begin
      w_valid       = bus.inp_w_valid_i[head];
      w_last        = bus.inp_w_last_i[head];
      w_ready[head] = bus.oup_w_ready_i;
    end
  end

  assign w_hs      = w_valid && bus.oup_w_ready_i;
  assign w_last_hs = w_hs && w_last;

  assign bus.aw_ready_o    = aw_ready;
  assign bus.inp_w_ready_o = w_ready;
  assign bus.oup_w_valid_o = w_valid;
  assign bus.oup_w_last_o  = w_last;
  // The head entry is itself a register, so selecting from it while
  // routing gives a registered select that advances right after a pop.
  assign bus.oup_w_sel_o   = (state_q == ROUTE) ? head : sel_hold_q;

  assign busy_o    = (state_q == ROUTE);
  assign pending_o = fifo_count;
  assign err_len_o = err_len_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      sel_hold_q <= '0;
      beat_cnt_q <= '0;
      err_len_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!fifo_empty) state_q <= ROUTE;
        end
        ROUTE: begin
          sel_hold_q <= head;
          if (w_hs) begin
            if (w_last) begin
              beat_cnt_q <= '0;
              // Another grant already queued (or arriving now) keeps
              // routing with no idle cycle between bursts.
              if (!((fifo_count > CW'(1)) || aw_push)) state_q <= IDLE;
            end else if (beat_cnt_q != CNT_W'(MAX_BEATS)) begin
              beat_cnt_q <= beat_cnt_q + CNT_W'(1);
              if (beat_cnt_q == CNT_W'(MAX_BEATS - 1)) err_len_q <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  a_no_aw_when_full: assert property (@(posedge clk_i) disable iff (rst_i)
    !(bus.aw_valid_i && !aw_ready))
    else $error("aw_valid_i asserted while the grant queue is full");
endmodule

// File: tb/tb_axi_node_w_sequencer.sv
module tb_axi_node_w_sequencer;
  localparam int unsigned NM = 4;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       busy_o;
  logic [3:0] pending_o;
  logic       err_len_o;

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned beats_seen = 0;

  int exp_q [$];          // expected beats in AW order: master*2 + last
  int bl [NM][16];        // per-master burst lengths still to send
  int bw [NM];
  int br [NM];
  logic [NM-1:0] hs_q;

  always #5 clk_i = ~clk_i;

  axi_node_w_sequencer_if #(.N_MASTER(NM)) bus ();

  axi_node_w_sequencer #(
    .N_MASTER  (NM),
    .DEPTH     (8),
    .MAX_BEATS (4)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .bus       (bus),
    .busy_o    (busy_o),
    .pending_o (pending_o),
    .err_len_o (err_len_o)
  );

  // Monitor: every beat accepted by the slave is checked against the queue.
  always @(negedge clk_i) begin
    int e;
    int act;
    hs_q = bus.inp_w_valid_i & bus.inp_w_ready_o;
    if (!rst_i && bus.oup_w_valid_o && bus.oup_w_ready_i) begin
      beats_seen++;
      checks++;
      act = int'(bus.oup_w_sel_o) * 2 + int'(bus.oup_w_last_o);
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL beat_unexpected: got sel*2+last=%0d, expected no beat", act);
      end else begin
        e = exp_q.pop_front();
        if (act != e || bus.inp_w_ready_o != (4'b0001 << bus.oup_w_sel_o)) begin
          errors++;
          $display("FAIL beat_order: got sel*2+last=%0d ready=%b, expected %0d ready onehot of sel",
                   act, bus.inp_w_ready_o, e);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive_w();
    for (int m = 0; m < NM; m++) begin
      bus.inp_w_valid_i[m] = (br[m] != bw[m]);
      bus.inp_w_last_i[m]  = (br[m] != bw[m]) && (bl[m][br[m] % 16] == 1);
    end
  endtask

  // Advance one cycle; afterwards the bench sits 2 time units past the edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
    for (int m = 0; m < NM; m++) begin
      if (hs_q[m] && br[m] != bw[m]) begin
        bl[m][br[m] % 16]--;
        if (bl[m][br[m] % 16] == 0) br[m]++;
      end
    end
    drive_w();
    #1;
  endtask

  task automatic aw_set(input int m, input int n);
    bus.aw_valid_i = 1'b1;
    bus.aw_mst_i   = 2'(m);
    for (int i = 0; i < n; i++) exp_q.push_back(m * 2 + ((i == n - 1) ? 1 : 0));
  endtask

  task automatic beats(input int m, input int n);
    bl[m][bw[m] % 16] = n;
    bw[m]++;
    drive_w();
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0;
    for (int m = 0; m < NM; m++) begin bw[m] = 0; br[m] = 0; end
    rst_i = 1'b1;
    bus.aw_valid_i = 1'b0;
    bus.aw_mst_i = '0;
    bus.inp_w_valid_i = '0;
    bus.inp_w_last_i = '0;
    bus.oup_w_ready_i = 1'b1;
    tick();
    tick();
    chk("rst_w_ready", int'(bus.inp_w_ready_o), 0);
    rst_i = 1'b0;
    #1;
    chk("rst_aw_ready", int'(bus.aw_ready_o), 1);
    chk("rst_pending", int'(pending_o), 0);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_err", int'(err_len_o), 0);
    chk("rst_sel", int'(bus.oup_w_sel_o), 0);
    chk("rst_oup_valid", int'(bus.oup_w_valid_o), 0);

    // Single 4-beat burst from master 2, beats in cycles 2..5.
    aw_set(2, 4);
    beats(2, 4);
    chk("t1_c0_oup_valid", int'(bus.oup_w_valid_o), 0);
    tick(); bus.aw_valid_i = 1'b0;
    chk("t1_c1_pending", int'(pending_o), 1);
    chk("t1_c1_oup_valid", int'(bus.oup_w_valid_o), 0);
    tick();
    chk("t1_c2_oup_valid", int'(bus.oup_w_valid_o), 1);
    chk("t1_c2_sel", int'(bus.oup_w_sel_o), 2);
    chk("t1_c2_busy", int'(busy_o), 1);
    tick(); tick(); tick();
    chk("t1_c5_last", int'(bus.oup_w_last_o), 1);
    chk("t1_c5_pending", int'(pending_o), 1);
    tick();
    chk("t1_c6_pending", int'(pending_o), 0);
    chk("t1_c6_busy", int'(busy_o), 0);
    chk("t1_c6_sel_hold", int'(bus.oup_w_sel_o), 2);
    chk("t1_c6_oup_valid", int'(bus.oup_w_valid_o), 0);

    // Master 3 is valid first but must wait behind master 1's grant.
    aw_set(1, 2);
    beats(1, 2);
    beats(3, 2);
    tick(); bus.aw_valid_i = 1'b0;
    aw_set(3, 2);
    #1;
    chk("t2_c1_m3_ready", int'(bus.inp_w_ready_o[3]), 0);
    tick(); bus.aw_valid_i = 1'b0;
    chk("t2_c2_m3_ready", int'(bus.inp_w_ready_o[3]), 0);
    chk("t2_c2_sel", int'(bus.oup_w_sel_o), 1);
    chk("t2_c2_pending", int'(pending_o), 2);
    tick();
    chk("t2_c3_m3_ready", int'(bus.inp_w_ready_o[3]), 0);
    chk("t2_c3_last", int'(bus.oup_w_last_o), 1);
    tick();
    chk("t2_c4_sel", int'(bus.oup_w_sel_o), 3);
    chk("t2_c4_oup_valid", int'(bus.oup_w_valid_o), 1);
    chk("t2_c4_ready", int'(bus.inp_w_ready_o), 8);
    chk("t2_c4_pending", int'(pending_o), 1);
    tick(); tick();
    chk("t2_busy_end", int'(busy_o), 0);
    chk("t2_queue_empty", exp_q.size(), 0);

    // Fill all 8 slots with single-beat grants, then drain.
    for (int i = 0; i < 8; i++) begin
      aw_set(i % 4, 1);
      tick();
      bus.aw_valid_i = 1'b0;
    end
    chk("t3_full_aw_ready", int'(bus.aw_ready_o), 0);
    chk("t3_full_pending", int'(pending_o), 8);
    beats(0, 1);
    tick();
    chk("t3_pop_pending", int'(pending_o), 7);
    chk("t3_pop_aw_ready", int'(bus.aw_ready_o), 1);
    beats(1, 1); beats(2, 1); beats(3, 1); beats(0, 1);
    beats(1, 1); beats(2, 1); beats(3, 1);
    for (int i = 0; i < 10; i++) tick();
    chk("t3_drain_pending", int'(pending_o), 0);
    chk("t3_queue_empty", exp_q.size(), 0);

    // Slave ready toggles during a 3-beat burst from master 0.
    b0 = int'(beats_seen);
    aw_set(0, 3);
    beats(0, 3);
    tick(); bus.aw_valid_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.oup_w_ready_i = (i % 2 == 1);
      #1;
      if (i == 2) begin
        chk("t4_stall_ready", int'(bus.inp_w_ready_o), 0);
        chk("t4_stall_valid", int'(bus.oup_w_valid_o), 1);
      end
      tick();
    end
    bus.oup_w_ready_i = 1'b1;
    chk("t4_beat_count", int'(beats_seen) - b0, 3);
    chk("t4_queue_empty", exp_q.size(), 0);

    // 6-beat burst against a 4-beat limit.
    aw_set(1, 6);
    beats(1, 6);
    tick(); bus.aw_valid_i = 1'b0;
    tick(); tick(); tick(); tick();
    chk("t5_err_before", int'(err_len_o), 0);
    tick();
    chk("t5_err_after4", int'(err_len_o), 1);
    tick(); tick();
    chk("t5_err_sticky", int'(err_len_o), 1);
    chk("t5_busy_end", int'(busy_o), 0);
    chk("t5_pending_end", int'(pending_o), 0);
    chk("t5_queue_empty", exp_q.size(), 0);

    // Reset asserted during beat 2 of a 3-beat burst.
    aw_set(2, 3);
    beats(2, 3);
    tick(); bus.aw_valid_i = 1'b0;
    tick();
    tick();
    rst_i = 1'b1;
    #1;
    chk("t6_rst_cycle_ready", int'(bus.inp_w_ready_o), 0);
    chk("t6_rst_cycle_valid", int'(bus.oup_w_valid_o), 0);
    tick();
    rst_i = 1'b0;
    exp_q.delete();
    br[2] = bw[2];
    drive_w();
    #1;
    chk("t6_ready", int'(bus.inp_w_ready_o), 0);
    chk("t6_pending", int'(pending_o), 0);
    chk("t6_aw_ready", int'(bus.aw_ready_o), 1);
    chk("t6_err", int'(err_len_o), 0);
    chk("t6_busy", int'(busy_o), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
